vga_sprite_pipeline: RTL

//  Pixel stage between vga_sync_module_640_480_60 and the VGA pins: maps the current

---
 rtl/vga_defs_pkg.sv | 21 ++
 rtl/vga_sprite_mover.sv | 46 ++++
 rtl/vga_sprite_pipeline.sv | 96 +++++++++
 3 files changed

// File: rtl/vga_defs_pkg.sv
// vga_defs_pkg: shared VGA timing, sprite geometry and RGB565 definitions
package vga_defs_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int SPRITE_W = 64;
   localparam int SPRITE_H = 64;
   localparam int LAT      = 3;
   localparam int R_W      = 5;
   localparam int G_W      = 6;
   localparam int B_W      = 5;
   localparam logic [15:0] RGB_BLACK = 16'h0000;
   localparam logic [15:0] RGB_WHITE = 16'hFFFF;
   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb565_t;
   function automatic rgb565_t expand_bits(input logic r, input logic g, input logic b);
      return '{r: {R_W{r}}, g: {G_W{g}}, b: {B_W{b}}};
   endfunction
endpackage

// File: rtl/vga_sprite_mover.sv
// vga_sprite_mover: bouncing sprite position, stepped once per VSYNC falling edge
//  clk, rst       : clock, synchronous active-high reset
//  vsync          : raw VSYNC (active-low); its 1->0 edge is the frame tick
//  xpos, ypos     : sprite top-left corner
module vga_sprite_mover import vga_defs_pkg::*; #(
   parameter int H_ACTIVE = vga_defs_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_defs_pkg::V_ACTIVE,
   parameter int X0       = 288,
   parameter int Y0       = 208
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   output logic [11:0] xpos,
   output logic [11:0] ypos
);
   localparam logic [11:0] X_MAX = 12'(H_ACTIVE - SPRITE_W);
   localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - SPRITE_H);
   logic        vs_q, dx_neg, dy_neg, tick, x_out, y_out;
   logic [11:0] x_nx, y_nx;
   // stepping below 0 wraps to a large value, so one upper compare covers both limits
   always_comb begin
      tick  = vs_q & ~vsync;
      x_nx  = dx_neg ? xpos - 12'd1 : xpos + 12'd1;
      y_nx  = dy_neg ? ypos - 12'd1 : ypos + 12'd1;
      x_out = x_nx > X_MAX;
      y_out = y_nx > Y_MAX;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q   <= 1'b1;
         xpos   <= 12'(X0);
         ypos   <= 12'(Y0);
         dx_neg <= 1'b0;
         dy_neg <= 1'b0;
      end else begin
         vs_q <= vsync;
         if (tick) begin
            xpos   <= x_out ? (dx_neg ? xpos + 12'd1 : xpos - 12'd1) : x_nx;
            ypos   <= y_out ? (dy_neg ? ypos + 12'd1 : ypos - 12'd1) : y_nx;
            dx_neg <= dx_neg ^ x_out;
            dy_neg <= dy_neg ^ y_out;
         end
      end
   end
endmodule

// File: rtl/vga_sprite_pipeline.sv
// vga_sprite_pipeline: 3-stage pixel pipeline drawing a 64x64 ROM sprite as RGB565
//  vga_clk, rst             : pixel clock, synchronous active-high reset
//  Ready_Sig, Column/Row    : visible flag and 0-based pixel coordinates
//  HSYNC_in, VSYNC_in       : raw active-low syncs, delayed 3 cycles to HSYNC_Sig/VSYNC_Sig
//  rom_addr, *_rom_data     : sprite row index out, 64-bit plane rows back one cycle later
//  Red/Green/Blue_Sig       : registered pixel colour
//  Macro VGA_SPRITE_MOVE_EN : sprite bounces one pixel per frame instead of staying at X0/Y0
module vga_sprite_pipeline import vga_defs_pkg::*; #(
   parameter int          H_ACTIVE = vga_defs_pkg::H_ACTIVE,
   parameter int          V_ACTIVE = vga_defs_pkg::V_ACTIVE,
   parameter int          X0       = 288,
   parameter int          Y0       = 208,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic        Ready_Sig,
   input  logic [11:0] Column_Addr_Sig,
   input  logic [11:0] Row_Addr_Sig,
   input  logic        HSYNC_in,
   input  logic        VSYNC_in,
   output logic [5:0]  rom_addr,
   input  logic [63:0] red_rom_data,
   input  logic [63:0] green_rom_data,
   input  logic [63:0] blue_rom_data,
   output logic [4:0]  Red_Sig,
   output logic [5:0]  Green_Sig,
   output logic [4:0]  Blue_Sig,
   output logic        HSYNC_Sig,
   output logic        VSYNC_Sig
);
   localparam logic [11:0] SW    = 12'(SPRITE_W);
   localparam logic [11:0] SH    = 12'(SPRITE_H);
   localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
   localparam logic [11:0] V_LIM = 12'(V_ACTIVE);
   logic [11:0] xpos, ypos, col_d, row_d;
   logic        hit, hit1, rdy1, hit2, rdy2, br, bg, bb;
   logic [5:0]  off1, off2, sel;
   logic [2:0]  hs_q, vs_q;
   rgb565_t     rgb_n, rgb_q;
`ifdef VGA_SPRITE_MOVE_EN
   vga_sprite_mover #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .X0(X0), .Y0(Y0)) u_mover (
      .clk   (vga_clk),
      .rst   (rst),
      .vsync (VSYNC_in),
      .xpos  (xpos),
      .ypos  (ypos)
   );
`else
   assign xpos = 12'(X0);
   assign ypos = 12'(Y0);
`endif
   // the >= checks reject negative offsets before the 6-bit truncation
   always_comb begin
      col_d = Column_Addr_Sig - xpos;
      row_d = Row_Addr_Sig - ypos;
      hit   = Ready_Sig && Column_Addr_Sig >= xpos && Row_Addr_Sig >= ypos &&
              col_d < SW && row_d < SH && Column_Addr_Sig < H_LIM && Row_Addr_Sig < V_LIM;
      sel   = ~off2;
      br    = red_rom_data[sel];
      bg    = green_rom_data[sel];
      bb    = blue_rom_data[sel];
      rgb_n = !rdy2 ? rgb565_t'(RGB_BLACK) :
              (hit2 && (br || bg || bb)) ? expand_bits(br, bg, bb) : rgb565_t'(BG_COLOR);
   end
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         rom_addr <= '0;
         hit1     <= 1'b0;
         rdy1     <= 1'b0;
         off1     <= '0;
         hit2     <= 1'b0;
         rdy2     <= 1'b0;
         off2     <= '0;
         rgb_q    <= rgb565_t'(RGB_BLACK);
         hs_q     <= '1;
         vs_q     <= '1;
      end else begin
         if (hit) rom_addr <= row_d[5:0];
         hit1  <= hit;
         rdy1  <= Ready_Sig;
         off1  <= col_d[5:0];
         hit2  <= hit1;
         rdy2  <= rdy1;
         off2  <= off1;
         rgb_q <= rgb_n;
         hs_q  <= {hs_q[1:0], HSYNC_in};
         vs_q  <= {vs_q[1:0], VSYNC_in};
      end
   end
   assign Red_Sig   = rgb_q.r;
   assign Green_Sig = rgb_q.g;
   assign Blue_Sig  = rgb_q.b;
   assign HSYNC_Sig = hs_q[2];
   assign VSYNC_Sig = vs_q[2];
endmodule
